ref_clk_train_ctrl: RTL and testbench



---
 rtl/ref_clk_train_ctrl.sv | 144 ++++++++++++++
 tb/tb_ref_clk_train_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ref_clk_train_ctrl.sv
// rtl/ref_clk_train_ctrl.sv - reference-clock IOD delay-line sweep and edge-finding trainer
module ref_clk_train_ctrl #(
    parameter int MAX_TAPS      = 128,
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLE_COUNT  = 8
) (
    input  logic       FAB_CLK,
    input  logic       RESET,
    input  logic       TRAIN_START,
    input  logic [7:0] RX_DATA,
    input  logic       EYE_MONITOR_EARLY,
    input  logic       EYE_MONITOR_LATE,
    input  logic       DELAY_LINE_OUT_OF_RANGE,
    output logic       DELAY_LINE_LOAD,
    output logic       DELAY_LINE_MOVE,
    output logic       DELAY_LINE_DIRECTION,
    output logic       EYE_MONITOR_CLEAR_FLAGS,
    output logic       BUSY,
    output logic       TRAIN_DONE,
    output logic       TRAIN_ERR,
    output logic [7:0] EDGE_TAP
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE, S_EVAL, S_MOVE, S_DONE, S_ERROR
    } state_t;

    localparam logic [7:0] LAST_TAP    = 8'(MAX_TAPS - 1);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] SAMPLE_LAST = 4'(SAMPLE_COUNT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_tap;
    logic [3:0] r_settle;
    logic [3:0] r_samp;
    logic [7:0] r_word;
    logic [7:0] r_ref;
    logic       r_ref_valid;
    logic       r_unstable;
    logic       r_done;
    logic       r_err;
    logic [7:0] r_edge;
    logic       w_edge_found;
    logic       w_at_last_tap;
    logic       w_flags;

    assign w_flags       = EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
    assign w_at_last_tap = (r_tap == LAST_TAP);
    // Once a reference exists, any instability or word change marks the clock edge.
    assign w_edge_found  = r_ref_valid && (r_unstable || (r_word != r_ref));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (TRAIN_START) w_next = S_LOAD;
            S_LOAD:   w_next = S_CLEAR;
            S_CLEAR:  w_next = S_SETTLE;
            S_SETTLE: begin
                if (DELAY_LINE_OUT_OF_RANGE) w_next = S_ERROR;
                else if (r_settle == 4'd0)   w_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (DELAY_LINE_OUT_OF_RANGE)   w_next = S_ERROR;
                else if (r_samp == SAMPLE_LAST) w_next = S_EVAL;
            end
            S_EVAL:   w_next = w_edge_found ? S_DONE : S_MOVE;
            S_MOVE:   w_next = w_at_last_tap ? S_ERROR : S_CLEAR;
            S_DONE:   w_next = S_IDLE;
            S_ERROR:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_tap       <= 8'd0;
            r_settle    <= 4'd0;
            r_samp      <= 4'd0;
            r_word      <= 8'd0;
            r_ref       <= 8'd0;
            r_ref_valid <= 1'b0;
            r_unstable  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_edge      <= 8'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (TRAIN_START) begin
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_edge      <= 8'd0;
                        r_tap       <= 8'd0;
                        r_ref_valid <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    r_settle <= SETTLE_INIT;
                    r_samp   <= 4'd0;
                end
                S_SETTLE: begin
                    if (r_settle != 4'd0) r_settle <= r_settle - 4'd1;
                end
                S_SAMPLE: begin
                    r_samp <= r_samp + 4'd1;
                    if (r_samp == 4'd0) begin
                        r_word     <= RX_DATA;
                        r_unstable <= w_flags;
                    end else if ((RX_DATA != r_word) || w_flags) begin
                        r_unstable <= 1'b1;
                    end
                end
                S_EVAL: begin
                    if (!r_unstable && !r_ref_valid) begin
                        r_ref       <= r_word;
                        r_ref_valid <= 1'b1;
                    end
                    if (w_edge_found) r_edge <= r_tap;
                end
                S_MOVE: begin
                    if (!w_at_last_tap) r_tap <= r_tap + 8'd1;
                end
                default: ;
            endcase
            if (w_next == S_DONE)  r_done <= 1'b1;
            if (w_next == S_ERROR) r_err  <= 1'b1;
        end
    end

    assign DELAY_LINE_LOAD         = (r_state == S_LOAD);
    assign DELAY_LINE_MOVE         = (r_state == S_MOVE) && !w_at_last_tap;
    assign EYE_MONITOR_CLEAR_FLAGS = (r_state == S_CLEAR);
    assign BUSY                    = (r_state == S_LOAD)   || (r_state == S_CLEAR) ||
                                     (r_state == S_SETTLE) || (r_state == S_SAMPLE) ||
                                     (r_state == S_EVAL)   || (r_state == S_MOVE);
    assign DELAY_LINE_DIRECTION    = BUSY;
    assign TRAIN_DONE              = r_done;
    assign TRAIN_ERR               = r_err;
    assign EDGE_TAP                = r_edge;

endmodule

// File: tb/tb_ref_clk_train_ctrl.sv
// tb/tb_ref_clk_train_ctrl.sv - directed self-checking bench for ref_clk_train_ctrl
module tb_ref_clk_train_ctrl;

    logic       FAB_CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       TRAIN_START = 1'b0;
    logic [7:0] RX_DATA = 8'h00;
    logic       EYE_MONITOR_EARLY = 1'b0;
    logic       EYE_MONITOR_LATE = 1'b0;
    logic       DELAY_LINE_OUT_OF_RANGE = 1'b0;
    logic       DELAY_LINE_LOAD;
    logic       DELAY_LINE_MOVE;
    logic       DELAY_LINE_DIRECTION;
    logic       EYE_MONITOR_CLEAR_FLAGS;
    logic       BUSY;
    logic       TRAIN_DONE;
    logic       TRAIN_ERR;
    logic [7:0] EDGE_TAP;

    int errors = 0;
    int checks = 0;
    int n_load, n_move, n_clear, n_cyc, last_k;
    int overlap_bad = 0;
    int dir_bad = 0;
    bit finished;

    ref_clk_train_ctrl #(.MAX_TAPS(128), .SETTLE_CYCLES(4), .SAMPLE_COUNT(8)) dut (
        .FAB_CLK                 (FAB_CLK),
        .RESET                   (RESET),
        .TRAIN_START             (TRAIN_START),
        .RX_DATA                 (RX_DATA),
        .EYE_MONITOR_EARLY       (EYE_MONITOR_EARLY),
        .EYE_MONITOR_LATE        (EYE_MONITOR_LATE),
        .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
        .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
        .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
        .EYE_MONITOR_CLEAR_FLAGS (EYE_MONITOR_CLEAR_FLAGS),
        .BUSY                    (BUSY),
        .TRAIN_DONE              (TRAIN_DONE),
        .TRAIN_ERR               (TRAIN_ERR),
        .EDGE_TAP                (EDGE_TAP)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    // Sweep driver: mode 0 = 0F below edge_t, F0 from edge_t; mode 1 = toggling
    // 0F/8F at taps 0..2 then as mode 0; mode 2 = constant 0F.
    task automatic run_sweep(input int mode, input int edge_t, input int late_tap,
                             input int oor_tap, input int rst_tap, input int restart_cyc);
        int tap = 0;
        int k = 0;
        n_load = 0; n_move = 0; n_clear = 0; n_cyc = 0; last_k = 0;
        finished = 1'b0;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            @(negedge FAB_CLK);
            TRAIN_START = 1'b0;
            n_cyc++;
            if ($countones({DELAY_LINE_LOAD, DELAY_LINE_MOVE, EYE_MONITOR_CLEAR_FLAGS}) > 1)
                overlap_bad++;
            if (DELAY_LINE_DIRECTION !== BUSY) dir_bad++;
            if (DELAY_LINE_LOAD) begin n_load++; tap = 0; k = 0; end
            else if (DELAY_LINE_MOVE) begin n_move++; tap++; k = 0; end
            else k++;
            if (EYE_MONITOR_CLEAR_FLAGS) begin n_clear++; EYE_MONITOR_LATE = 1'b0; end
            last_k = k;
            if (TRAIN_DONE || TRAIN_ERR) begin finished = 1'b1; break; end
            if (tap == rst_tap && k == 8) begin RESET = 1'b1; finished = 1'b1; break; end
            if (restart_cyc > 0 && n_cyc == restart_cyc) TRAIN_START = 1'b1;
            if (tap == late_tap && k == 8) EYE_MONITOR_LATE = 1'b1;
            if (tap == oor_tap && k == 3) DELAY_LINE_OUT_OF_RANGE = 1'b1;
            if (mode == 2) RX_DATA = 8'h0F;
            else if (mode == 1 && tap <= 2) RX_DATA = n_cyc[0] ? 8'h8F : 8'h0F;
            else RX_DATA = (tap < edge_t) ? 8'h0F : 8'hF0;
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL sweep_timeout: got no DONE/ERR after %0d cycles, required completion", n_cyc);
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        repeat (3) @(negedge FAB_CLK);
        checks++;
        if ({DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS,
             BUSY, TRAIN_DONE, TRAIN_ERR, EDGE_TAP} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b err=%0b edge=%0d, required all 0",
                     BUSY, TRAIN_DONE, TRAIN_ERR, EDGE_TAP);
        end
        TRAIN_START = 1'b1;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || DELAY_LINE_LOAD !== 1'b0) begin
            errors++;
            $display("FAIL reset_beats_start: got busy=%0b load=%0b, required 0/0", BUSY, DELAY_LINE_LOAD);
        end
        RESET = 1'b0;
        @(negedge FAB_CLK);
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%0b, required 0", BUSY);
        end
    endtask

    task automatic test_edge_sweep;
        run_sweep(0, 37, -1, -1, -1, 0);
        checks++;
        if (EDGE_TAP !== 8'd37 || TRAIN_DONE !== 1'b1 || TRAIN_ERR !== 1'b0) begin
            errors++;
            $display("FAIL edge37_result: got edge=%0d done=%0b err=%0b, required 37/1/0",
                     EDGE_TAP, TRAIN_DONE, TRAIN_ERR);
        end
        checks++;
        if (n_move != 37 || n_load != 1 || n_clear != 38) begin
            errors++;
            $display("FAIL edge37_pulses: got move=%0d load=%0d clear=%0d, required 37/1/38",
                     n_move, n_load, n_clear);
        end
        checks++;
        if (n_cyc != 571 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL edge37_latency: got cycles=%0d busy=%0b, required 571/0", n_cyc, BUSY);
        end
        repeat (3) @(negedge FAB_CLK);
        checks++;
        if (TRAIN_DONE !== 1'b1 || EDGE_TAP !== 8'd37 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL done_sticky: got done=%0b edge=%0d busy=%0b, required 1/37/0",
                     TRAIN_DONE, EDGE_TAP, BUSY);
        end
    endtask

    task automatic test_jitter_skip;
        run_sweep(1, 11, -1, -1, -1, 0);
        checks++;
        if (EDGE_TAP !== 8'd11 || TRAIN_DONE !== 1'b1 || n_move != 11) begin
            errors++;
            $display("FAIL jitter_skip: got edge=%0d done=%0b moves=%0d, required 11/1/11",
                     EDGE_TAP, TRAIN_DONE, n_move);
        end
    endtask

    task automatic test_no_edge;
        run_sweep(2, 1000, -1, -1, -1, 0);
        checks++;
        if (TRAIN_ERR !== 1'b1 || TRAIN_DONE !== 1'b0) begin
            errors++;
            $display("FAIL no_edge_flags: got err=%0b done=%0b, required 1/0", TRAIN_ERR, TRAIN_DONE);
        end
        checks++;
        if (n_move != 127 || n_clear != 128) begin
            errors++;
            $display("FAIL no_edge_moves: got move=%0d clear=%0d, required 127/128", n_move, n_clear);
        end
    endtask

    task automatic test_out_of_range;
        int late_moves = 0;
        run_sweep(2, 1000, -1, 20, -1, 0);
        checks++;
        if (TRAIN_ERR !== 1'b1 || TRAIN_DONE !== 1'b0 || BUSY !== 1'b0 || last_k != 4) begin
            errors++;
            $display("FAIL oor_error: got err=%0b done=%0b busy=%0b at_k=%0d, required 1/0/0/4",
                     TRAIN_ERR, TRAIN_DONE, BUSY, last_k);
        end
        DELAY_LINE_OUT_OF_RANGE = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge FAB_CLK);
            if (DELAY_LINE_MOVE) late_moves++;
        end
        checks++;
        if (n_move != 20 || late_moves != 0 || TRAIN_ERR !== 1'b1) begin
            errors++;
            $display("FAIL oor_moves: got moves=%0d after=%0d err=%0b, required 20/0/1",
                     n_move, late_moves, TRAIN_ERR);
        end
    endtask

    task automatic test_eye_late;
        run_sweep(0, 1000, 15, -1, -1, 0);
        EYE_MONITOR_LATE = 1'b0;
        checks++;
        if (EDGE_TAP !== 8'd15 || TRAIN_DONE !== 1'b1 || TRAIN_ERR !== 1'b0) begin
            errors++;
            $display("FAIL eye_late: got edge=%0d done=%0b err=%0b, required 15/1/0",
                     EDGE_TAP, TRAIN_DONE, TRAIN_ERR);
        end
    endtask

    task automatic test_reset_mid_sweep;
        run_sweep(0, 30, -1, -1, 9, 0);
        @(negedge FAB_CLK);
        checks++;
        if ({DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS,
             BUSY, TRAIN_DONE, TRAIN_ERR, EDGE_TAP} !== 15'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got busy=%0b done=%0b dir=%0b edge=%0d, required all 0",
                     BUSY, TRAIN_DONE, DELAY_LINE_DIRECTION, EDGE_TAP);
        end
        RESET = 1'b0;
        run_sweep(0, 5, -1, -1, -1, 10);
        checks++;
        if (n_load != 1 || EDGE_TAP !== 8'd5 || TRAIN_DONE !== 1'b1 || n_move != 5) begin
            errors++;
            $display("FAIL restart_sweep: got loads=%0d edge=%0d done=%0b moves=%0d, required 1/5/1/5",
                     n_load, EDGE_TAP, TRAIN_DONE, n_move);
        end
    endtask

    task automatic test_output_rules;
        checks++;
        if (overlap_bad != 0 || dir_bad != 0) begin
            errors++;
            $display("FAIL output_rules: got overlap=%0d dir_mismatch=%0d, required 0/0",
                     overlap_bad, dir_bad);
        end
    endtask

    initial begin
        test_reset();
        test_edge_sweep();
        test_jitter_skip();
        test_no_edge();
        test_out_of_range();
        test_eye_late();
        test_reset_mid_sweep();
        test_output_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
